if_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface: owns the program counter, drives the byte address into the combinational instruction memory and captures the returned 32-bit big-endian word into the IF/ID pipeline register.
- Handles the pipeline-hazard controls: a stall from the hazard detector and a flush/redirect from branch resolution.
- Sits between the hazard/branch logic and the decode stage of the 5-stage pipeline.

---
 rtl/if_fetch_unit_if.sv | 29 ++
 rtl/if_fetch_unit.sv | 99 +++++++++
 tb/tb_if_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if
//   Bundles the fetch stage's hazard controls, instruction-memory port
//   and IF/ID pipeline register outputs.
//   master : the fetch unit (drives o_*, receives i_*)
//   slave  : the surrounding pipeline / memory / testbench
interface if_fetch_unit_if;
    logic        i_stall;       // hold PC and IF/ID
    logic        i_flush;       // squash IF/ID, redirect PC
    logic [31:0] i_target;      // redirect byte address
    logic [31:0] o_im_addr;     // byte address to instruction memory
    logic [31:0] i_im_instr;    // word returned by memory for o_im_addr
    logic [31:0] o_ifid_instr;  // IF/ID instruction
    logic [31:0] o_ifid_pc;     // IF/ID instruction address
    logic [31:0] o_ifid_pc4;    // IF/ID pc+4
    logic        o_ifid_valid;  // 0 = bubble
    logic        o_misalign;    // sticky misaligned-redirect flag

    modport master (
        input  i_stall, i_flush, i_target, i_im_instr,
        output o_im_addr, o_ifid_instr, o_ifid_pc, o_ifid_pc4,
               o_ifid_valid, o_misalign
    );

    modport slave (
        output i_stall, i_flush, i_target, i_im_instr,
        input  o_im_addr, o_ifid_instr, o_ifid_pc, o_ifid_pc4,
               o_ifid_valid, o_misalign
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage: owns the PC, addresses the combinational
//   instruction memory and captures the returned word into IF/ID.
//   Edge priority: reset > flush > stall > normal fetch.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : if_fetch_unit_if.master (hazard controls, memory port, IF/ID)
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 32'h0;
            ifpc4_q <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    // BOOT, RUN and HOLD share the same edge rules; the state records
    // where we are (first fetch, streaming, frozen) for observability.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        valid_d = valid_q;
        mis_d   = mis_q;

        if (bus.i_flush) begin
            // Older branch wins over a simultaneous stall.
            state_d = RUN;
            pc_d    = {bus.i_target[31:2], 2'b00};
            instr_d = NOP_INSTR;
            ifpc_d  = 32'h0;
            ifpc4_d = 32'h0;
            valid_d = 1'b0;
            mis_d   = mis_q | (bus.i_target[1:0] != 2'b00);
        end else if (bus.i_stall) begin
            state_d = HOLD;
        end else begin
            unique case (state_q)
                BOOT, RUN, HOLD: state_d = RUN;
                default:         state_d = RUN;
            endcase
            pc_d    = pc_plus4;
            instr_d = bus.i_im_instr;
            ifpc_d  = pc_q;
            ifpc4_d = pc_plus4;
            valid_d = 1'b1;
        end
    end

    // Address comes from the PC register only: no input-to-memory path.
    assign bus.o_im_addr    = pc_q;
    assign bus.o_ifid_instr = instr_q;
    assign bus.o_ifid_pc    = ifpc_q;
    assign bus.o_ifid_pc4   = ifpc4_q;
    assign bus.o_ifid_valid = valid_q;
    assign bus.o_misalign   = mis_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
//   Directed plus randomized bench for if_fetch_unit. A hashed-address
//   memory feeds the DUT; a per-edge reference model tracks the expected
//   PC and IF/ID contents from the fetch rules.
module tb_if_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] seed;

    // Reference state
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
    logic        m_valid, m_mis;

    if_fetch_unit_if ifc ();

    if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s ^ {a[15:0], a[31:16]};
    endfunction

    assign ifc.i_im_instr = memf(ifc.o_im_addr, seed);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".im_addr"},  ifc.o_im_addr,    m_pc);
        chk({tag, ".instr"},    ifc.o_ifid_instr, m_instr);
        chk({tag, ".pc"},       ifc.o_ifid_pc,    m_ifpc);
        chk({tag, ".pc4"},      ifc.o_ifid_pc4,   m_ifpc4);
        chk({tag, ".valid"},    {31'h0, ifc.o_ifid_valid}, {31'h0, m_valid});
        chk({tag, ".misalign"}, {31'h0, ifc.o_misalign},   {31'h0, m_mis});
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_instr = NOP; m_ifpc = 0; m_ifpc4 = 0;
        m_valid = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic [31:0] tgt);
        if (fl) begin
            m_instr = NOP; m_ifpc = 0; m_ifpc4 = 0; m_valid = 1'b0;
            m_pc = tgt & 32'hFFFF_FFFC;
            if (tgt % 4 != 0) m_mis = 1'b1;
        end else if (!st) begin
            m_instr = memf(m_pc, seed);
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    // Called from the low clock phase; drives, takes one edge, checks,
    // and returns at the next falling edge.
    task automatic step(input logic st, input logic fl, input logic [31:0] tgt, input string tag);
        ifc.i_stall = st; ifc.i_flush = fl; ifc.i_target = tgt;
        @(posedge clk);
        model_edge(st, fl, tgt);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between edges, checked before any edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        ifc.i_stall = 0; ifc.i_flush = 0; ifc.i_target = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        seed = $urandom;
        ifc.i_stall = 0; ifc.i_flush = 0; ifc.i_target = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Boot and sequential fetch up to IF/ID pc = 0x10
        step(0, 0, 0, "boot0");
        step(0, 0, 0, "seq4");
        for (int i = 0; i < 3; i++) step(0, 0, 0, "seq");
        chk("seq.at10", ifc.o_ifid_pc, 32'h10);

        // Three stalled edges then release
        for (int i = 0; i < 3; i++) step(1, 0, 0, "stall");
        step(0, 0, 0, "stall_rel");

        // Advance to PC = 0x20 then redirect to 0x40
        step(0, 0, 0, "seq");
        step(0, 0, 0, "seq");
        chk("pre_flush.pc20", ifc.o_im_addr, 32'h20);
        step(0, 1, 32'h40, "flush40");
        step(0, 0, 0, "flush40_tgt");

        // Flush with simultaneous stall
        step(1, 1, 32'h80, "flush_stall");
        step(0, 0, 0, "flush_stall_tgt");

        // Misaligned target: sticky until reset
        step(0, 1, 32'h43, "mis43");
        step(0, 0, 0, "mis_hold");
        step(1, 0, 0, "mis_hold2");
        async_reset("mis_reset");
        step(0, 0, 0, "post_rst");

        // PC wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, "wrap_flush");
        step(0, 0, 0, "wrap");
        step(0, 0, 0, "wrap_next");

        // Async reset in the middle of a hold
        step(1, 0, 0, "hold");
        step(1, 0, 0, "hold");
        ifc.i_stall = 1;
        async_reset("hold_reset");
        step(0, 0, 0, "boot_again");

        // Random hazards
        for (int i = 0; i < 400; i++) begin
            logic        st, fl;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 59) == 0) async_reset("rnd_reset");
            else step(st, fl, tgt, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
